// File: rtl/wwd_display_sink_pkg.sv
// ============================================================================
// Module      : wwd_display_sink_pkg
// Description : Shared constants for the WWD display sink: word width,
//               active-low hex-to-segment table and blank digit-enable value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wwd_display_sink_pkg;

   localparam int WORD_SIZE = 16;

   localparam logic [3:0] AN_OFF = 4'b1111;

   // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment. Entry 15 listed first.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0001110,   // F
      7'b0000110,   // E
      7'b0100001,   // d
      7'b1000110,   // C
      7'b0000011,   // b
      7'b0001000,   // A
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

endpackage

`default_nettype wire

// File: rtl/wwd_display_sink_seg7_hex_decode.sv
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational nibble to active-low 7-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_decode
   import wwd_display_sink_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = HEX_SEG[i_nibble];

endmodule

`default_nettype wire

// File: rtl/wwd_display_sink.sv
// ============================================================================
// Module      : wwd_display_sink
// Description : Buffers CPU WWD words in a small FIFO and shows the current
//               word as four hex digits on a multiplexed 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wwd_display_sink
   import wwd_display_sink_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SCAN_DIV    = 16,
   parameter int HOLD_CYCLES = 64
) (
   input  logic                        clk,
   input  logic                        reset_cpu_n,
   input  logic                        wwd_valid,
   input  logic [WORD_SIZE-1:0]        wwd_data,
   output logic                        wwd_ready,
   input  logic                        advance,
   input  logic                        auto_mode,
   output logic [6:0]                  seg,
   output logic [3:0]                  an,
   output logic [$clog2(FIFO_DEPTH):0] occupancy,
   output logic                        overflow
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int SCAN_W = $clog2(SCAN_DIV + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   logic [WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]     r_count;
   logic                 r_overflow;
   logic [WORD_SIZE-1:0] r_shown;
   logic                 r_sync1;
   logic                 r_sync2;
   logic                 r_sync3;
   logic [HOLD_W-1:0]    r_hold;
   logic [SCAN_W-1:0]    r_scan;
   logic [1:0]           r_digit;
   logic [6:0]           r_seg;
   logic [3:0]           r_an;

   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_btn_req;
   logic                 w_hold_tc;
   logic                 w_auto_req;
   logic [3:0]           w_nibble;
   logic [6:0]           w_seg;

   assign w_empty    = (r_count == '0);
   assign wwd_ready  = (r_count != CNT_W'(FIFO_DEPTH));
   assign w_push     = wwd_valid & wwd_ready;
   assign w_btn_req  = r_sync2 & ~r_sync3 & ~auto_mode;
   assign w_hold_tc  = (r_hold == HOLD_W'(HOLD_CYCLES - 1));
   assign w_auto_req = auto_mode & ~w_empty & w_hold_tc;
   // A request against an empty FIFO is dropped; there is no push-to-display bypass.
   assign w_pop      = (w_btn_req | w_auto_req) & ~w_empty;
   assign w_nibble   = r_shown[{r_digit, 2'b00} +: 4];

   assign seg       = r_seg;
   assign an        = r_an;
   assign occupancy = r_count;
   assign overflow  = r_overflow;

   seg7_hex_decode u_decode (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wwd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_cpu_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_shown    <= '0;
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_sync3    <= 1'b0;
         r_hold     <= '0;
         r_scan     <= '0;
         r_digit    <= 2'd0;
         r_seg      <= HEX_SEG[4'h0];
         r_an       <= AN_OFF & ~4'b0001;
      end else begin
         r_sync1 <= advance;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_shown  <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase

         if (wwd_valid && !wwd_ready) begin
            r_overflow <= 1'b1;
         end

         if (!auto_mode || w_empty || w_hold_tc) begin
            r_hold <= '0;
         end else begin
            r_hold <= r_hold + HOLD_W'(1);
         end

         if (r_scan == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan  <= '0;
            r_digit <= r_digit + 2'd1;
         end else begin
            r_scan  <= r_scan + SCAN_W'(1);
         end

         r_an  <= AN_OFF & ~(4'b0001 << r_digit);
         r_seg <= w_seg;
      end
   end

endmodule

`default_nettype wire

// File: doc/wwd_display_sink.md
Name: wwd_display_sink

Overview:
- Consumer end of the CPU's WWD output path.
- Accepts 16-bit words pushed by the CPU on each WWD instruction and buffers them in a small FIFO.
- Presents them one at a time as 4 hex digits on a multiplexed, active-low 7-segment display. Words advance on a button press or on an auto-advance timer.
- Applies back-pressure (wwd_ready) so the CPU stalls instead of losing words.

Parameters:
WORD_SIZE, 16, data word width (4 hex nibbles)
FIFO_DEPTH, 4, buffered words; power of two, at least 2
SCAN_DIV, 16, clk cycles each digit is driven before the scan moves on
HOLD_CYCLES, 64, auto-advance period in clk cycles

Ports:
clk  in  1  system clock, all state on rising edge
reset_cpu_n  in  1  reset, synchronous, active-low
wwd_valid  in  1  CPU presents a WWD word this cycle
wwd_data  in  WORD_SIZE  word to display
wwd_ready  out  1  FIFO can accept (= not full)
advance  in  1  raw asynchronous button level; rising edge pops one word
auto_mode  in  1  1 = pop on HOLD_CYCLES timer instead of button
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
an  out  4  digit enables, active-low, one-hot-low
occupancy  out  clog2(FIFO_DEPTH)+1  words held in FIFO
overflow  out  1  sticky; a push was attempted while full

Behaviour:
- Reset (reset_cpu_n=0 at a clk edge) clears all state, including mid-push or mid-scan:
  - FIFO empty, occupancy=0, wwd_ready=1, overflow=0
  - shown_word=0, synchronizer and edge flops 0, timers 0, digit index 0
  - Outputs on the next cycle: an=4'b1110, seg = pattern for hex 0 (7'b1000000)
- Push: a word is accepted when wwd_valid and wwd_ready are both 1 at a clk edge. It is written at the tail, and occupancy increments.
- wwd_ready = (occupancy != FIFO_DEPTH). It is combinational from registered state only and has no path from wwd_valid.
- overflow is set when wwd_valid=1 and wwd_ready=0. It stays set until reset.
- Button path:
  - advance passes through a 2-flop synchronizer.
  - Edge = sync2 & ~sync3, where sync3 is a third flop.
  - A pop request is raised 3 cycles after advance rises. Holding the button gives exactly one request.
- Auto path: with auto_mode=1 and the FIFO not empty, hold_cnt counts 0..HOLD_CYCLES-1. The terminal count raises a pop request and wraps to 0. hold_cnt resets to 0 when auto_mode=0 or the FIFO is empty.
- Button edges are ignored while auto_mode=1.
- Pop: a pop request with the FIFO not empty moves the head into shown_word at that edge, advances the head, and decrements occupancy.
- A pop request with the FIFO empty is dropped: no state change, shown_word holds.
- Push and pop in the same cycle:
  - Not full and not empty: both happen, occupancy unchanged.
  - Empty: push only, no bypass, pop dropped.
  - Full: pop only, because wwd_ready was 0.
- Pointers wrap modulo FIFO_DEPTH.
- Scanner:
  - scan_cnt counts 0..SCAN_DIV-1. On terminal count, digit index increments mod 4.
  - Digit index i drives an with bit i=0 and selects nibble shown_word[4i+3:4i]. Digit 0 is the least significant nibble.
  - seg and an are registered: they reflect the digit index and shown_word one cycle after either changes.
  - an is never all-zero and never shows more than one zero bit.
- Hex decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Shared package: WORD_SIZE, the 16-entry hex-to-segment constant table, and the AN_OFF constant (4'b1111).
- One sub-module, seg7_hex_decode: 4-bit nibble in, 7-bit active-low segments out, purely combinational.
- FIFO, synchronizer, timers and scanner stay in this module.

Test Plan:
- Reset then idle 4*SCAN_DIV cycles:
  - an cycles 1110→1101→1011→0111 every 16 cycles.
  - seg=1000000 throughout.
  - wwd_ready=1, occupancy=0.
- Push 16'h1234, pulse advance (auto_mode=0):
  - Pop 3 cycles after the rise; shown_word=1234.
  - Digit 0 shows 0011001 ("4"), digit 3 shows 1111001 ("1").
  - occupancy returns to 0.
- Push 5 words 0xA000..0xA004 back-to-back with wwd_valid held:
  - First 4 accepted; wwd_ready=0 after the 4th.
  - overflow=1 while the 5th is offered.
  - Press advance once: 5th accepted the next cycle.
- auto_mode=1 with FIFO holding 0x00FF, 0xBEEF:
  - Pops at cycles 64 and 128 after entry.
  - shown_word=00FF, then BEEF.
  - Timer then idles with occupancy=0; shown_word stays BEEF.
- Same-cycle push and pop at occupancy=2: occupancy stays 2 and FIFO order is preserved. Same-cycle push and pop at occupancy=0: occupancy becomes 1 and shown_word is unchanged.
- Assert reset_cpu_n=0 for one cycle mid-scan with FIFO at 3 words: next cycle occupancy=0, overflow=0, shown_word=0, an=1110.
